// File: rtl/result_bus_arbiter.sv
// Result broadcast bus arbiter: each functional unit owns a 2-entry result FIFO,
// and a round-robin arbiter drains one FIFO head per cycle onto a registered bus.
module result_bus_arbiter #(
    parameter int NUM_FU       = 4,
    parameter int PRN_BITS     = 6,
    parameter int INST_ID_BITS = 6,
    parameter int BUF_DEPTH    = 2,
    localparam int SRC_W       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [NUM_FU-1:0]                      fu_valid,
    output logic [NUM_FU-1:0]                      fu_ready,
    input  logic [NUM_FU-1:0][PRN_BITS-1:0]        fu_prn,
    input  logic [NUM_FU-1:0][INST_ID_BITS-1:0]    fu_inst_id,
    input  logic [NUM_FU-1:0][63:0]                fu_value,
    output logic                                   result_valid,
    output logic [PRN_BITS-1:0]                    result_prn,
    output logic [INST_ID_BITS-1:0]                result_inst_id,
    output logic [63:0]                            result_value,
    output logic [SRC_W-1:0]                       result_src
);

    localparam int ENT_W = PRN_BITS + INST_ID_BITS + 64;

    logic [ENT_W-1:0]           r_mem [NUM_FU][2];
    logic [NUM_FU-1:0][1:0]     r_cnt;
    logic [NUM_FU-1:0][1:0]     w_cnt_nxt;
    logic [NUM_FU-1:0]          r_rd_ptr;
    logic [NUM_FU-1:0]          r_wr_ptr;
    logic [NUM_FU-1:0]          r_ready;
    logic [NUM_FU-1:0]          w_push;
    logic [NUM_FU-1:0]          w_pop;
    logic [NUM_FU-1:0]          w_nonempty;
    logic [SRC_W-1:0]           r_rr_ptr;
    logic [SRC_W-1:0]           w_gnt_idx;
    logic [SRC_W-1:0]           w_rr_nxt;
    logic                       w_gnt_vld;
    logic [ENT_W-1:0]           w_head;

    logic                       r_res_vld;
    logic [PRN_BITS-1:0]        r_res_prn;
    logic [INST_ID_BITS-1:0]    r_res_id;
    logic [63:0]                r_res_val;
    logic [SRC_W-1:0]           r_res_src;

    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            w_nonempty[k] = (r_cnt[k] != 2'd0);
            w_push[k]     = fu_valid[k] && r_ready[k];
        end
    end

    // Two passes: the second (indices at or above rr_ptr) overrides the first,
    // so the lowest index >= rr_ptr wins, otherwise the lowest index below it.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (w_nonempty[k] && (k < int'(r_rr_ptr))) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = SRC_W'(k);
            end
        end
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (w_nonempty[k] && (k >= int'(r_rr_ptr))) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = SRC_W'(k);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            w_pop[k]     = w_gnt_vld && (w_gnt_idx == SRC_W'(k));
            w_cnt_nxt[k] = r_cnt[k] + {1'b0, w_push[k]} - {1'b0, w_pop[k]};
        end
        w_head   = r_mem[w_gnt_idx][r_rd_ptr[w_gnt_idx]];
        w_rr_nxt = (w_gnt_idx == SRC_W'(NUM_FU - 1)) ? '0 : w_gnt_idx + SRC_W'(1);
    end

    // Ready is registered from next occupancy, so a full FIFO can never be pushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_ready  <= '1;
            r_rr_ptr <= '0;
        end else if (flush) begin
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_ready  <= '1;
            r_rr_ptr <= '0;
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                r_cnt[k]   <= w_cnt_nxt[k];
                r_ready[k] <= (w_cnt_nxt[k] < 2'(BUF_DEPTH));
                if (w_push[k]) r_wr_ptr[k] <= ~r_wr_ptr[k];
                if (w_pop[k])  r_rd_ptr[k] <= ~r_rd_ptr[k];
            end
            if (w_gnt_vld) r_rr_ptr <= w_rr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_FU; k++) begin
            if (rst && !flush && w_push[k])
                r_mem[k][r_wr_ptr[k]] <= {fu_prn[k], fu_inst_id[k], fu_value[k]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_vld <= 1'b0;
            r_res_prn <= '0;
            r_res_id  <= '0;
            r_res_val <= '0;
            r_res_src <= '0;
        end else if (flush) begin
            r_res_vld <= 1'b0;
        end else begin
            r_res_vld <= w_gnt_vld;
            if (w_gnt_vld) begin
                {r_res_prn, r_res_id, r_res_val} <= w_head;
                r_res_src <= w_gnt_idx;
            end
        end
    end

    assign fu_ready       = r_ready;
    assign result_valid   = r_res_vld;
    assign result_prn     = r_res_prn;
    assign result_inst_id = r_res_id;
    assign result_value   = r_res_val;
    assign result_src     = r_res_src;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Bench for result_bus_arbiter: table of single-result vectors, hand-written
// contention/backpressure/flush/reset sequences, and a per-FU ordering scoreboard.
module tb_result_bus_arbiter;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [3:0]        fu_valid = '0;
    logic [3:0]        fu_ready;
    logic [3:0][5:0]   fu_prn = '0;
    logic [3:0][5:0]   fu_inst_id = '0;
    logic [3:0][63:0]  fu_value = '0;
    logic              result_valid;
    logic [5:0]        result_prn;
    logic [5:0]        result_inst_id;
    logic [63:0]       result_value;
    logic [1:0]        result_src;

    always #5 clk = ~clk;

    result_bus_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .fu_valid       (fu_valid),
        .fu_ready       (fu_ready),
        .fu_prn         (fu_prn),
        .fu_inst_id     (fu_inst_id),
        .fu_value       (fu_value),
        .result_valid   (result_valid),
        .result_prn     (result_prn),
        .result_inst_id (result_inst_id),
        .result_value   (result_value),
        .result_src     (result_src)
    );

    typedef struct packed {
        logic [1:0]  src;
        logic [5:0]  prn;
        logic [5:0]  id;
        logic [63:0] val;
    } sb_t;

    typedef struct {
        logic [1:0]  fu;
        logic [5:0]  prn;
        logic [5:0]  id;
        logic [63:0] val;
        logic [1:0]  exp_src;
        logic [5:0]  exp_prn;
        logic [5:0]  exp_id;
        logic [63:0] exp_val;
    } vec_t;

    sb_t  sb_q[$];
    vec_t tbl[4];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mon_idx;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] k, input logic [5:0] prn, input logic [5:0] id,
                         input logic [63:0] val, input bit accept);
        sb_t e;
        fu_valid[k]   = 1'b1;
        fu_prn[k]     = prn;
        fu_inst_id[k] = id;
        fu_value[k]   = val;
        if (accept) begin
            e.src = k; e.prn = prn; e.id = id; e.val = val;
            sb_q.push_back(e);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb_q.delete();
    endtask

    // Each broadcast must match the oldest outstanding entry of the same FU.
    always @(negedge clk) begin
        if (rst && result_valid) begin
            mon_idx = -1;
            for (int i = 0; i < sb_q.size(); i++)
                if (mon_idx < 0 && sb_q[i].src == result_src) mon_idx = i;
            n_tests++;
            if (mon_idx < 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got src %0d prn %0d, expected no broadcast",
                         result_src, result_prn);
            end else begin
                if ({result_prn, result_inst_id, result_value} !==
                    {sb_q[mon_idx].prn, sb_q[mon_idx].id, sb_q[mon_idx].val}) begin
                    n_fail++;
                    $display("FAIL sb_data src %0d: got %0h/%0h/%0h, expected %0h/%0h/%0h",
                             result_src, result_prn, result_inst_id, result_value,
                             sb_q[mon_idx].prn, sb_q[mon_idx].id, sb_q[mon_idx].val);
                end
                sb_q.delete(mon_idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'd2, 6'd5,  6'd9,  64'hDEAD,               2'd2, 6'd5,  6'd9,  64'hDEAD};
        tbl[1] = '{2'd0, 6'd0,  6'd0,  64'h0,                  2'd0, 6'd0,  6'd0,  64'h0};
        tbl[2] = '{2'd3, 6'd63, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 6'd63, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[3] = '{2'd1, 6'h2A, 6'h15, 64'h0123_4567_89AB_CDEF, 2'd1, 6'h2A, 6'h15, 64'h0123_4567_89AB_CDEF};

        #1 rst = 1'b0;
        repeat (3) tick();
        check("rst_valid", 80'(result_valid), 80'(0));
        check("rst_prn",   80'(result_prn),   80'(0));
        check("rst_id",    80'(result_inst_id), 80'(0));
        check("rst_value", 80'(result_value), 80'(0));
        check("rst_src",   80'(result_src),   80'(0));
        check("rst_ready", 80'(fu_ready),     80'(4'hF));
        rst = 1'b1;
        tick();

        for (int r = 0; r < 4; r++) begin
            drive(tbl[r].fu, tbl[r].prn, tbl[r].id, tbl[r].val, 1'b1);
            tick();
            fu_valid = '0;
            check("tbl_latency_valid", 80'(result_valid), 80'(0));
            tick();
            check("tbl_valid", 80'(result_valid),   80'(1));
            check("tbl_prn",   80'(result_prn),     80'(tbl[r].exp_prn));
            check("tbl_id",    80'(result_inst_id), 80'(tbl[r].exp_id));
            check("tbl_value", 80'(result_value),   80'(tbl[r].exp_val));
            check("tbl_src",   80'(result_src),     80'(tbl[r].exp_src));
            tick();
            check("tbl_valid_drop", 80'(result_valid), 80'(0));
            check("tbl_prn_hold",   80'(result_prn),   80'(tbl[r].exp_prn));
        end

        // Contention from rr_ptr=0.
        do_flush();
        for (int k = 0; k < 4; k++)
            drive(2'(k), 6'(10 + k), 6'(20 + k), 64'(k + 1) * 64'h1111, 1'b1);
        tick();
        fu_valid = '0;
        check("cont_latency", 80'(result_valid), 80'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cont_valid", 80'(result_valid), 80'(1));
            check("cont_src",   80'(result_src),   80'(i));
        end
        tick();
        check("cont_idle", 80'(result_valid), 80'(0));
        drive(2'd0, 6'd1, 6'd2, 64'hA0, 1'b1);
        drive(2'd3, 6'd3, 6'd4, 64'hA3, 1'b1);
        tick();
        fu_valid = '0;
        tick();
        check("cont_rr_end_first", 80'(result_src), 80'(0));
        tick();
        check("cont_rr_end_second", 80'(result_src), 80'(3));

        // Steer rr_ptr to 3 via a grant to FU2, then FU3 and FU0 contend.
        drive(2'd2, 6'd7, 6'd8, 64'hB2, 1'b1);
        tick();
        fu_valid = '0;
        tick();
        check("wrap_setup_src", 80'(result_src), 80'(2));
        drive(2'd3, 6'd11, 6'd12, 64'hC3, 1'b1);
        drive(2'd0, 6'd13, 6'd14, 64'hC0, 1'b1);
        tick();
        fu_valid = '0;
        tick();
        check("wrap_first",  80'(result_src), 80'(3));
        tick();
        check("wrap_second", 80'(result_src), 80'(0));
        tick();

        // Backpressure on FU1 while FU0 stays busy.
        do_flush();
        drive(2'd0, 6'd40, 6'd0, 64'hA000, 1'b1);
        drive(2'd1, 6'd50, 6'd1, 64'hD000, 1'b1);
        tick();
        check("bp_ready_e1", 80'(fu_ready[1]), 80'(1));
        drive(2'd0, 6'd41, 6'd2, 64'hA001, 1'b1);
        drive(2'd1, 6'd51, 6'd3, 64'hD001, 1'b1);
        tick();
        check("bp_ready_e2", 80'(fu_ready[1]), 80'(0));
        check("bp_src_e2",   80'(result_src),  80'(0));
        drive(2'd0, 6'd42, 6'd4, 64'hA002, 1'b1);
        drive(2'd1, 6'd52, 6'd5, 64'hD002, 1'b1);
        tick();
        check("bp_ready_e3", 80'(fu_ready[1]), 80'(1));
        check("bp_src_e3",   80'(result_src),  80'(1));
        fu_valid[0] = 1'b0;
        tick();
        check("bp_ready_e4", 80'(fu_ready[1]), 80'(0));
        check("bp_src_e4",   80'(result_src),  80'(0));
        fu_valid = '0;
        tick();
        check("bp_ready_e5", 80'(fu_ready[1]), 80'(1));
        check("bp_src_e5",   80'(result_src),  80'(1));
        tick();
        check("bp_src_e6", 80'(result_src), 80'(0));
        tick();
        check("bp_src_e7", 80'(result_src), 80'(1));
        tick();
        check("bp_idle",    80'(result_valid), 80'(0));
        check("bp_no_loss", 80'(sb_q.size()),  80'(0));
        check("bp_ready_all", 80'(fu_ready),   80'(4'hF));

        // Flush with five entries buffered and a push presented on the flush edge.
        for (int k = 0; k < 4; k++)
            drive(2'(k), 6'(30 + k), 6'(k), 64'(k) + 64'hF00, 1'b1);
        tick();
        fu_valid = '0;
        drive(2'd1, 6'd35, 6'd5, 64'hF11, 1'b1);
        drive(2'd2, 6'd36, 6'd6, 64'hF22, 1'b1);
        tick();
        fu_valid = '0;
        drive(2'd3, 6'd37, 6'd7, 64'hF33, 1'b0);
        do_flush();
        fu_valid = '0;
        check("flush_valid", 80'(result_valid), 80'(0));
        check("flush_ready", 80'(fu_ready),     80'(4'hF));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_no_stale", 80'(result_valid), 80'(0));
        end

        // Asynchronous reset mid-cycle with a result on the bus.
        drive(2'd0, 6'd21, 6'd22, 64'h5A5A, 1'b1);
        drive(2'd1, 6'd23, 6'd24, 64'h6B6B, 1'b1);
        tick();
        fu_valid = '0;
        tick();
        check("arst_pre_valid", 80'(result_valid), 80'(1));
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 80'(result_valid),   80'(0));
        check("arst_prn",   80'(result_prn),     80'(0));
        check("arst_id",    80'(result_inst_id), 80'(0));
        check("arst_value", 80'(result_value),   80'(0));
        check("arst_src",   80'(result_src),     80'(0));
        check("arst_ready", 80'(fu_ready),       80'(4'hF));
        sb_q.delete();
        tick();
        rst = 1'b1;
        drive(2'd3, 6'd44, 6'd45, 64'h7777, 1'b1);
        tick();
        fu_valid = '0;
        check("arst_no_stale", 80'(result_valid), 80'(0));
        tick();
        check("arst_first_valid", 80'(result_valid), 80'(1));
        check("arst_first_src",   80'(result_src),   80'(3));
        check("arst_first_prn",   80'(result_prn),   80'(44));
        tick();
        check("arst_idle",  80'(result_valid), 80'(0));
        check("final_drain", 80'(sb_q.size()), 80'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
